// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional build macro: SEQ_DIVIDER_SIGNED_EN (two's-complement operands).
package seq_divider_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int MAX_WIDTH = 64;

    // Divide-by-zero quotient; sliced down to the instance width.
    localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between a controlling FSM and the divider.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_trial_sub.sv
// Trial subtractor a - b as a full-adder ripple on ~b with carry-in 1.
// borrow is the inverted carry-out.
module div_trial_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);
    logic [W:0]   c;
    logic [W-1:0] nb;

    assign c[0] = 1'b1;
    assign nb   = ~b;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign diff[i]  = a[i] ^ nb[i] ^ c[i];
        assign c[i+1]   = (a[i] & nb[i]) | (a[i] & c[i]) | (nb[i] & c[i]);
    end

    assign borrow = ~c[W];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one shift/trial-subtract per clock, start/done handshake.
// Optional build macro: SEQ_DIVIDER_SIGNED_EN (signed operands, sign fix-up at result load).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state, state_nxt;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] dvd_cap;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] q_res, r_res;
    logic [WIDTH-1:0] q_out, r_out;
    logic             dbz_out, done_out;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg, r_neg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction
`endif

    // Restored remainder is always below the divisor, so its top bit is
    // implicitly zero and only WIDTH bits are kept between iterations.
    assign r_sh = {rem_q, dvd_sh[WIDTH-1]};

    div_trial_sub #(.W(WIDTH + 1)) u_trial (
        .a      (r_sh),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE, FIN: begin
                state_nxt = IDLE;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = (bus.divisor == '0) ? FIN : RUN;
                end
            end
            RUN:     if (cnt == LAST) state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_res = q_acc;
        r_res = rem_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (q_neg) q_res = ~q_acc + WIDTH'(1);
        if (r_neg) r_res = ~rem_q + WIDTH'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem_q    <= '0;
            dvd_sh   <= '0;
            dvd_cap  <= '0;
            dvs      <= '0;
            q_acc    <= '0;
            q_out    <= '0;
            r_out    <= '0;
            dbz_out  <= 1'b0;
            done_out <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            done_out <= 1'b0;
            // Results of the finishing op load on the same edge that may
            // accept the next op, which gives back-to-back throughput.
            if (state == FIN) begin
                done_out <= 1'b1;
                if (dvs == '0) begin
                    q_out   <= DBZ_QUOTIENT[WIDTH-1:0];
                    r_out   <= dvd_cap;
                    dbz_out <= 1'b1;
                end else begin
                    q_out   <= q_res;
                    r_out   <= r_res;
                    dbz_out <= 1'b0;
                end
            end
            if (accept) begin
                cnt     <= '0;
                rem_q   <= '0;
                q_acc   <= '0;
                dvd_cap <= bus.dividend;
`ifdef SEQ_DIVIDER_SIGNED_EN
                dvd_sh  <= mag(bus.dividend);
                dvs     <= mag(bus.divisor);
                q_neg   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                r_neg   <= bus.dividend[WIDTH-1];
`else
                dvd_sh  <= bus.dividend;
                dvs     <= bus.divisor;
`endif
            end else if (state == RUN) begin
                rem_q  <= borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                q_acc  <= {q_acc[WIDTH-2:0], ~borrow};
                dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
                cnt    <= cnt + CW'(1);
            end
        end
    end

    // A successful trial never leaves a difference at or above 2^WIDTH.
    always_ff @(posedge clk) begin
        if (rst_n && state == RUN) assert (borrow || !diff[WIDTH]);
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = done_out;
    assign bus.quotient    = q_out;
    assign bus.remainder   = r_out;
    assign bus.div_by_zero = dbz_out;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed spec vectors plus randomized
// back-to-back traffic against a plain-arithmetic reference model.
module tb_seq_divider;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        logic signed [W-1:0] sa_w, sb_w;
        int sa, sb;
        sa_w = a; sb_w = b;
        sa = sa_w; sb = sb_w;
        if (b == '0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            z = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q = W'(sa / sb);
            r = W'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Issues one op from idle and waits (bounded) for done; lat=0 means timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                          output logic bsy, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z);
        @(negedge clk);
        bus.dividend = a; bus.divisor = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bsy = bus.busy;
        lat = 0; q = '0; r = '0; z = 1'b0;
        for (int i = 1; i <= 4 * W + 8; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i; q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat; logic bsy, z; logic [W-1:0] q, r, eq, er;
`ifdef SEQ_DIVIDER_SIGNED_EN
        eq = 4'd15; er = 4'd0;
`else
        eq = 4'd4;  er = 4'd1;
`endif
        run_op(4'd13, 4'd3, lat, bsy, q, r, z);
        checks++; if (lat !== W + 1) begin failures++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (bsy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", bsy); end
        checks++; if (q !== eq || r !== er || z !== 1'b0) begin
            failures++; $display("FAIL basic_13_3: got q=%0d r=%0d z=%b want q=%0d r=%0d z=0", q, r, z, eq, er);
        end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL basic_done_width: got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        checks++; if (bus.quotient !== eq || bus.remainder !== er) begin
            failures++; $display("FAIL basic_hold: got q=%0d r=%0d want q=%0d r=%0d", bus.quotient, bus.remainder, eq, er);
        end
    endtask

    task automatic test_div_zero;
        int lat; logic bsy, z; logic [W-1:0] q, r;
        run_op(4'd7, 4'd0, lat, bsy, q, r, z);
        checks++; if (lat !== 1) begin failures++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        checks++; if (bsy !== 1'b0) begin failures++; $display("FAIL dbz_busy: got %b want 0", bsy); end
        checks++; if (q !== 4'd15 || r !== 4'd7 || z !== 1'b1) begin
            failures++; $display("FAIL dbz_7_0: got q=%0d r=%0d z=%b want q=15 r=7 z=1", q, r, z);
        end
        run_op(4'd6, 4'd2, lat, bsy, q, r, z);
        checks++; if (q !== 4'd3 || r !== 4'd0 || z !== 1'b0 || lat !== W + 1) begin
            failures++; $display("FAIL dbz_clear_6_2: got q=%0d r=%0d z=%b lat=%0d want q=3 r=0 z=0 lat=%0d", q, r, z, lat, W + 1);
        end
    endtask

    task automatic test_boundaries;
        // These three give identical bit patterns in signed and unsigned builds.
        logic [W-1:0] ta[3] = '{4'd15, 4'd2, 4'd15};
        logic [W-1:0] tb[3] = '{4'd1,  4'd9, 4'd15};
        logic [W-1:0] tq[3] = '{4'd15, 4'd0, 4'd1};
        logic [W-1:0] tr[3] = '{4'd0,  4'd2, 4'd0};
        int lat; logic bsy, z; logic [W-1:0] q, r;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], lat, bsy, q, r, z);
            checks++;
            if (q !== tq[i] || r !== tr[i] || z !== 1'b0 || lat !== W + 1) begin
                failures++;
                $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=0 lat=%0d",
                         ta[i], tb[i], q, r, z, lat, tq[i], tr[i], W + 1);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [W-1:0] eq, er, eq2, er2; logic ez, ez2, early; int lat;
        model(4'd13, 4'd3, eq, er, ez);
        model(4'd9, 4'd4, eq2, er2, ez2);
        @(negedge clk);
        bus.dividend = 4'd13; bus.divisor = 4'd3; bus.start = 1'b1;
        @(posedge clk); #1;                               // edge k
        bus.start = 1'b0;
        early = 1'b0;
        @(negedge clk);
        bus.dividend = 4'd5; bus.divisor = 4'd1; bus.start = 1'b1;
        @(posedge clk); #1;                               // edge k+1, mid-RUN start
        early |= bus.done;
        bus.start = 1'b0; bus.dividend = 4'd0; bus.divisor = 4'd0;
        repeat (W - 1) begin @(posedge clk); #1; early |= bus.done; end   // through edge k+W
        checks++; if (early !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL ignore_fin_state: got early_done=%b busy=%b want 0 0", early, bus.busy);
        end
        @(negedge clk);
        bus.dividend = 4'd9; bus.divisor = 4'd4; bus.start = 1'b1;
        @(posedge clk); #1;                               // edge k+W+1, start accepted in FIN
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.quotient !== eq || bus.remainder !== er || bus.busy !== 1'b1) begin
            failures++; $display("FAIL ignore_result: got done=%b q=%0d r=%0d busy=%b want done=1 q=%0d r=%0d busy=1",
                                 bus.done, bus.quotient, bus.remainder, bus.busy, eq, er);
        end
        lat = 0;
        for (int i = 1; i <= 4 * W; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = i; break; end
        end
        checks++; if (lat !== W + 1 || bus.quotient !== eq2 || bus.remainder !== er2 || bus.div_by_zero !== ez2) begin
            failures++; $display("FAIL fin_start_9_4: got lat=%0d q=%0d r=%0d z=%b want lat=%0d q=%0d r=%0d z=%b",
                                 lat, bus.quotient, bus.remainder, bus.div_by_zero, W + 1, eq2, er2, ez2);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat; logic bsy, z, seen; logic [W-1:0] q, r, eq, er; logic ez;
        @(negedge clk);
        bus.dividend = 4'd13; bus.divisor = 4'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (2 * W) begin @(posedge clk); #1; seen |= bus.done; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrun_no_done: got done pulse=%b want 0", seen); end
        model(4'd10, 4'd3, eq, er, ez);
        run_op(4'd10, 4'd3, lat, bsy, q, r, z);
        checks++; if (q !== eq || r !== er || z !== ez || lat !== W + 1) begin
            failures++; $display("FAIL after_reset_10_3: got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=%b lat=%0d",
                                 q, r, z, lat, eq, er, ez, W + 1);
        end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed;
        logic [W-1:0] ta[3] = '{4'b1001, 4'd7,    4'b1000};
        logic [W-1:0] tb[3] = '{4'd2,    4'b1110, 4'b1111};
        logic [W-1:0] tq[3] = '{4'b1101, 4'b1101, 4'b1000};
        logic [W-1:0] tr[3] = '{4'b1111, 4'd1,    4'd0};
        int lat; logic bsy, z; logic [W-1:0] q, r;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], lat, bsy, q, r, z);
            checks++;
            if (q !== tq[i] || r !== tr[i] || z !== 1'b0 || lat !== W + 1) begin
                failures++;
                $display("FAIL signed_%b_%b: got q=%b r=%b z=%b lat=%0d want q=%b r=%b z=0",
                         ta[i], tb[i], q, r, z, lat, tq[i], tr[i]);
            end
        end
    endtask
`endif

    // Random traffic; a new op is offered whenever busy is low (IDLE or FIN),
    // and junk starts are thrown in while busy to confirm they are ignored.
    task automatic test_back_to_back;
        localparam int N = 60;
        logic [W-1:0] qa[$], qb[$];
        int           qe[$];
        logic [W-1:0] a, b, eq, er, pa, pb, q, r;
        logic         ez, drove, z;
        int           edge_n, issued, got, pe, want_lat;
        edge_n = 0; issued = 0; got = 0;
        for (int cyc = 0; cyc < 3000 && got < N; cyc++) begin
            @(negedge clk);
            drove = 1'b0;
            if (!bus.busy && issued < N) begin
                a = W'($urandom);
                b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
                bus.dividend = a; bus.divisor = b; bus.start = 1'b1;
                drove = 1'b1; issued++;
            end else if (bus.busy && $urandom_range(0, 2) == 0) begin
                bus.dividend = W'($urandom); bus.divisor = W'($urandom); bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); edge_n++; #1;
            q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
            if (drove) begin qa.push_back(a); qb.push_back(b); qe.push_back(edge_n); end
            bus.start = 1'b0;
            if (bus.done) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++; $display("FAIL b2b_spurious_done: got done at edge %0d want none", edge_n);
                end else begin
                    pa = qa.pop_front(); pb = qb.pop_front(); pe = qe.pop_front();
                    got++;
                    model(pa, pb, eq, er, ez);
                    want_lat = (pb == '0) ? 1 : W + 1;
                    if (q !== eq || r !== er || z !== ez || edge_n - pe !== want_lat) begin
                        failures++;
                        $display("FAIL b2b_%0d_%0d: got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=%b lat=%0d",
                                 pa, pb, q, r, z, edge_n - pe, eq, er, ez, want_lat);
                    end
                end
            end
        end
        checks++;
        if (got !== N) begin failures++; $display("FAIL b2b_count: got %0d results want %0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_start_ignored();
        test_reset_mid_run();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
